// File: rtl/enc4to2_hs.sv
// enc4to2_hs: registered 4-to-2 priority encoder with valid/ready handshakes and sticky multi-hot error.
// Define ENC4TO2_ERRCNT_EN to add the saturating 8-bit err_cnt output.
module enc4to2_hs #(
    parameter bit DROP_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       e,
    input  logic [3:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] a,
    output logic       multi,
    output logic       idle,
    output logic       err,
    input  logic       err_clr
`ifdef ENC4TO2_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    logic       vld_q, vld_d;
    logic [1:0] a_q, a_d;
    logic       multi_q, multi_d;
    logic       idle_q, idle_d;
    logic       err_q, err_d;

    logic [1:0] enc_a;
    logic [2:0] ones;
    logic       beat_multi, beat_idle, accept, load;

    // Highest set line wins, matching the 2-to-4 decoder mapping.
    always_comb begin
        enc_a = 2'd0;
        if (y[3])      enc_a = 2'd3;
        else if (y[2]) enc_a = 2'd2;
        else if (y[1]) enc_a = 2'd1;
    end

    assign ones       = {2'b00, y[0]} + {2'b00, y[1]} + {2'b00, y[2]} + {2'b00, y[3]};
    assign beat_multi = e && (ones >= 3'd2);
    assign beat_idle  = !e || (y == 4'b0000);
    assign in_ready   = !rst && (!vld_q || out_ready);
    assign accept     = in_valid && in_ready;
    // Idle beats are swallowed entirely when DROP_IDLE is set.
    assign load       = accept && (!beat_idle || !DROP_IDLE);

    always_comb begin
        vld_d   = vld_q;
        a_d     = a_q;
        multi_d = multi_q;
        idle_d  = idle_q;
        if (load) begin
            vld_d   = 1'b1;
            a_d     = beat_idle ? 2'd0 : enc_a;
            multi_d = beat_idle ? 1'b0 : beat_multi;
            idle_d  = beat_idle;
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
        err_d = err_q;
        if (accept && beat_multi) err_d = 1'b1;
        else if (err_clr)         err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            a_q     <= 2'd0;
            multi_q <= 1'b0;
            idle_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            a_q     <= a_d;
            multi_q <= multi_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign a         = a_q;
    assign multi     = multi_q;
    assign idle      = idle_q;
    assign err       = err_q;

`ifdef ENC4TO2_ERRCNT_EN
    logic [7:0] cnt_q, cnt_d;

    // A clear coinciding with a new error leaves exactly that one error counted.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && beat_multi) begin
            if (err_clr)               cnt_d = 8'd1;
            else if (cnt_q != 8'hFF)   cnt_d = cnt_q + 8'd1;
        end else if (err_clr) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_enc4to2_hs.sv
// Bench for enc4to2_hs: both DROP_IDLE builds driven in parallel and compared every cycle to a beat-level model.
module tb_enc4to2_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, e, out_ready, err_clr;
    logic [3:0] y;
    logic [1:0] in_ready, out_valid, multi, idle, err;
    logic [1:0] a_o [2];
`ifdef ENC4TO2_ERRCNT_EN
    logic [7:0] cnt_o [2];
`endif

    // index 0: DROP_IDLE=1, index 1: DROP_IDLE=0
    enc4to2_hs #(.DROP_IDLE(1'b1)) u_drop (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .e(e), .y(y), .out_valid(out_valid[0]), .out_ready(out_ready),
        .a(a_o[0]), .multi(multi[0]), .idle(idle[0]), .err(err[0]), .err_clr(err_clr)
`ifdef ENC4TO2_ERRCNT_EN
        , .err_cnt(cnt_o[0])
`endif
    );

    enc4to2_hs #(.DROP_IDLE(1'b0)) u_keep (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .e(e), .y(y), .out_valid(out_valid[1]), .out_ready(out_ready),
        .a(a_o[1]), .multi(multi[1]), .idle(idle[1]), .err(err[1]), .err_clr(err_clr)
`ifdef ENC4TO2_ERRCNT_EN
        , .err_cnt(cnt_o[1])
`endif
    );

    // Reference state: what each instance should be presenting after the next edge.
    bit m_vld [2];
    int m_a   [2];
    bit m_multi [2];
    bit m_idle  [2];
    bit m_err   [2];
    int m_cnt   [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    function automatic int hi_idx(input logic [3:0] v);
        for (int i = 3; i >= 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit rdy, acc, idl, mh, keep_idle;
            rdy       = !rst && (!m_vld[k] || out_ready);
            acc       = in_valid && rdy;
            idl       = !e || (y == 4'b0000);
            mh        = e && ($countones(y) >= 2);
            keep_idle = (k == 1);
            chk("in_ready", k, {31'd0, in_ready[k]}, {31'd0, rdy});
            if (rst) begin
                m_vld[k] = 0; m_a[k] = 0; m_multi[k] = 0; m_idle[k] = 0;
                m_err[k] = 0; m_cnt[k] = 0;
            end else begin
                if (acc && (!idl || keep_idle)) begin
                    m_vld[k]   = 1;
                    m_a[k]     = idl ? 0 : hi_idx(y);
                    m_multi[k] = mh;
                    m_idle[k]  = idl;
                end else if (m_vld[k] && out_ready) begin
                    m_vld[k] = 0;
                end
                if (acc && mh) m_err[k] = 1;
                else if (err_clr) m_err[k] = 0;
                if (acc && mh) m_cnt[k] = err_clr ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
                else if (err_clr) m_cnt[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, {31'd0, out_valid[k]}, {31'd0, m_vld[k]});
            chk("a",         k, {30'd0, a_o[k]},       m_a[k]);
            chk("multi",     k, {31'd0, multi[k]},     {31'd0, m_multi[k]});
            chk("idle",      k, {31'd0, idle[k]},      {31'd0, m_idle[k]});
            chk("err",       k, {31'd0, err[k]},       {31'd0, m_err[k]});
`ifdef ENC4TO2_ERRCNT_EN
            chk("err_cnt",   k, {24'd0, cnt_o[k]},     m_cnt[k]);
`endif
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit ee, input logic [3:0] yy,
                         input bit ordy, input bit clr);
        rst = r; in_valid = v; e = ee; y = yy; out_ready = ordy; err_clr = clr;
        cycle();
    endtask

    function automatic logic [3:0] rand_multi();
        logic [3:0] v;
        v = 4'($urandom_range(15, 0));
        while ($countones(v) < 2) v = 4'($urandom_range(15, 0));
        return v;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 0; m_a[k] = 0; m_multi[k] = 0; m_idle[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end
        rst = 1; in_valid = 1; e = 1; y = 4'b1000; out_ready = 1; err_clr = 0;

        // reset held two cycles with a beat offered
        drive(1, 1, 1, 4'b1000, 1, 0);
        drive(1, 1, 1, 4'b1000, 1, 0);
        drive(0, 0, 1, 4'b1000, 1, 0);
        drive(0, 0, 1, 4'b1000, 1, 0);

        // one-hot beats back to back
        drive(0, 1, 1, 4'b0001, 1, 0);
        drive(0, 1, 1, 4'b0010, 1, 0);
        drive(0, 1, 1, 4'b0100, 1, 0);
        drive(0, 1, 1, 4'b1000, 1, 0);
        drive(0, 0, 1, 4'b0000, 1, 0);

        // multi-hot, then set-vs-clear in the same cycle
        drive(0, 1, 1, 4'b0110, 1, 0);
        drive(0, 1, 1, 4'b1001, 1, 1);
        drive(0, 0, 1, 4'b0000, 1, 0);

        // idle beats
        drive(0, 1, 0, 4'b1000, 1, 0);
        drive(0, 1, 1, 4'b0000, 1, 0);
        drive(0, 0, 1, 4'b0000, 1, 0);

        // backpressure then drain-and-load in one cycle
        drive(0, 1, 1, 4'b0100, 1, 0);
        drive(0, 1, 1, 4'b1000, 0, 0);
        drive(0, 1, 1, 4'b1000, 0, 0);
        drive(0, 1, 1, 4'b1000, 0, 0);
        drive(0, 1, 1, 4'b1000, 1, 0);
        drive(0, 0, 1, 4'b0000, 1, 0);

        // reset while a result is held
        drive(0, 1, 1, 4'b0010, 0, 0);
        drive(0, 1, 1, 4'b0100, 0, 0);
        drive(1, 0, 1, 4'b0000, 0, 0);
        drive(0, 0, 1, 4'b0000, 1, 0);
        drive(0, 0, 1, 4'b0000, 1, 0);

        // counter saturation: one set-with-clear, then 300 more multi-hot beats
        drive(0, 1, 1, 4'b0011, 1, 1);
        for (int i = 0; i < 300; i++) drive(0, 1, 1, rand_multi(), 1, 0);
        drive(0, 0, 1, 4'b0000, 1, 1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(49, 0) == 0),
                  1'($urandom_range(1, 0)),
                  ($urandom_range(3, 0) != 0),
                  4'($urandom_range(15, 0)),
                  ($urandom_range(2, 0) != 0),
                  ($urandom_range(7, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
